// File: rtl/video_pkg.sv
// Package for the video output stream generator.
// Contents: FSM state type vout_state_t, default size/blanking constants and
// small constant helpers used to size the position and blanking counters.
// No ports.
package video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2
    } vout_state_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_WIDTH   = 640;
    localparam int DEF_HEIGHT  = 480;
    localparam int DEF_H_BLANK = 50;
    localparam int DEF_V_BLANK = 100;

    // Counter width for a range of 'value' states, never narrower than one bit
    // so a 1-line frame still gets a legal row counter.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/video_out_stream_if.sv
// FIFO read-side handshake between the frame FIFO and video_out_stream.
// Signals: pixel_in (show-ahead head word), fifo_avail (FIFO non-empty),
// r_ack (pop, one clk per consumed word).
// Modports: master = FIFO side, slave = pixel consumer (video_out_stream).
interface video_out_stream_if
    import video_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();
    logic [DATA_W-1:0] pixel_in;
    logic              fifo_avail;
    logic              r_ack;

    modport master (output pixel_in, output fifo_avail, input r_ack);
    modport slave  (input pixel_in, input fifo_avail, output r_ack);
endinterface

// File: rtl/video_out_timing.sv
// Frame timing FSM for video_out_stream: IDLE (vertical blanking), ACTIVE
// (pixels of a line), HBLANK (line blanking). Advances only on pix_en ticks.
// Ports: clk, RST (async, active-high), pix_en, en (start permission),
// start_ok (a frame may be sourced), state, col, row, frame_end (ACTIVE on
// the last pixel of the last line).
module video_out_timing
    import video_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT,
    parameter int H_BLANK = DEF_H_BLANK,
    parameter int V_BLANK = DEF_V_BLANK,
    parameter int COL_W   = clog2_min1(WIDTH),
    parameter int ROW_W   = clog2_min1(HEIGHT)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             pix_en,
    input  logic             en,
    input  logic             start_ok,
    output vout_state_t      state,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             frame_end
);
    localparam int BLK_W = clog2_min1(max_int(H_BLANK, V_BLANK) + 1);

    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(HEIGHT - 1);
    localparam logic [BLK_W-1:0] BLK_V_END   = BLK_W'(V_BLANK);
    localparam logic [BLK_W-1:0] BLK_H_END   = BLK_W'(H_BLANK - 1);

    vout_state_t      state_nxt;
    logic [COL_W-1:0] col_nxt;
    logic [ROW_W-1:0] row_nxt;
    logic [BLK_W-1:0] blk;
    logic [BLK_W-1:0] blk_nxt;

    // State and counter registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            col   <= {COL_W{1'b0}};
            row   <= {ROW_W{1'b0}};
            blk   <= {BLK_W{1'b0}};
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
            blk   <= blk_nxt;
        end
    end

    // Next-state and counter update; everything holds between pix_en ticks.
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        blk_nxt   = blk;
        if (pix_en) begin
            case (state)
                ST_IDLE: begin
                    // blk saturates at V_BLANK so a late start begins immediately.
                    if ((blk == BLK_V_END) && en && start_ok) begin
                        state_nxt = ST_ACTIVE;
                        col_nxt   = {COL_W{1'b0}};
                        row_nxt   = {ROW_W{1'b0}};
                    end else if (blk != BLK_V_END) begin
                        blk_nxt = blk + BLK_W'(1);
                    end else begin
                        blk_nxt = blk;
                    end
                end
                ST_ACTIVE: begin
                    if (col == COL_LAST) begin
                        blk_nxt = {BLK_W{1'b0}};
                        if (row == ROW_LAST) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_HBLANK;
                            row_nxt   = row + ROW_W'(1);
                        end
                    end else begin
                        col_nxt = col + COL_W'(1);
                    end
                end
                ST_HBLANK: begin
                    // Mid-frame lines start regardless of FIFO level; a short
                    // FIFO shows up as underflow rather than a timing slip.
                    if (blk == BLK_H_END) begin
                        state_nxt = ST_ACTIVE;
                        col_nxt   = {COL_W{1'b0}};
                    end else begin
                        blk_nxt = blk + BLK_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    col_nxt   = {COL_W{1'b0}};
                    row_nxt   = {ROW_W{1'b0}};
                    blk_nxt   = {BLK_W{1'b0}};
                end
            endcase
        end else begin
            state_nxt = state;
        end
    end

    // Last pixel of the frame is being emitted this tick.
    always_comb begin
        frame_end = (state == ST_ACTIVE) && (col == COL_LAST) && (row == ROW_LAST);
    end

endmodule

// File: rtl/video_out_stream.sv
// Video output generator: drains a show-ahead FIFO and emits frame_valid,
// line_valid and pixel_out with programmable active size and blanking.
// Ports: clk, RST (async, active-high), pix_en (pixel-rate strobe), en (start
// permission), fifo (FIFO read handshake, slave side), pixel_out,
// frame_valid, line_valid, frame_done (one-clk end-of-frame pulse),
// underflow (sticky), underflow_clr.
// Optional feature macro VIDEO_OUT_PATTERN_EN adds input pattern_sel which,
// when 1 at frame start, replaces FIFO data with a col^row test pattern.
module video_out_stream
    import video_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT,
    parameter int H_BLANK = DEF_H_BLANK,
    parameter int V_BLANK = DEF_V_BLANK
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              pix_en,
    input  logic              en,
    video_out_stream_if.slave fifo,
    output logic [DATA_W-1:0] pixel_out,
    output logic              frame_valid,
    output logic              line_valid,
    output logic              frame_done,
    output logic              underflow,
`ifdef VIDEO_OUT_PATTERN_EN
    input  logic              pattern_sel,
`endif
    input  logic              underflow_clr
);
    localparam int COL_W = clog2_min1(WIDTH);
    localparam int ROW_W = clog2_min1(HEIGHT);

    vout_state_t       state_s;
    logic [COL_W-1:0]  col_s;
    logic [ROW_W-1:0]  row_s;
    logic              frame_end_s;
    logic              start_ok_s;
    logic              use_fifo_s;
    logic [DATA_W-1:0] pat_pix_s;
    logic [DATA_W-1:0] pix_sel_s;
    logic              active_tick_s;
    logic              uf_set_s;

    video_out_timing #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .H_BLANK(H_BLANK),
        .V_BLANK(V_BLANK),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_timing (
        .clk      (clk),
        .RST      (RST),
        .pix_en   (pix_en),
        .en       (en),
        .start_ok (start_ok_s),
        .state    (state_s),
        .col      (col_s),
        .row      (row_s),
        .frame_end(frame_end_s)
    );

`ifdef VIDEO_OUT_PATTERN_EN
    localparam int XOR_W = max_int(DATA_W, max_int(COL_W, ROW_W));

    logic             pattern_r;
    logic [XOR_W-1:0] pat_xor_s;

    // pattern_sel is captured on every idle tick, so the value seen on the
    // start tick is frozen for the whole frame.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            pattern_r <= 1'b0;
        end else if (pix_en && (state_s == ST_IDLE)) begin
            pattern_r <= pattern_sel;
        end else begin
            pattern_r <= pattern_r;
        end
    end

    // Pattern source: a pattern frame may start with an empty FIFO.
    always_comb begin
        pat_xor_s  = XOR_W'(col_s) ^ XOR_W'(row_s);
        pat_pix_s  = pat_xor_s[DATA_W-1:0];
        start_ok_s = fifo.fifo_avail | pattern_sel;
        use_fifo_s = ~pattern_r;
    end
`else
    logic unused_pos_s;

    // Without the pattern generator the frame position is not needed here.
    always_comb begin
        unused_pos_s = ^{col_s, row_s};
        pat_pix_s    = {DATA_W{1'b0}};
        start_ok_s   = fifo.fifo_avail;
        use_fifo_s   = 1'b1;
    end
`endif

    // FIFO pop, underflow detection and pixel source select.
    always_comb begin
        active_tick_s = pix_en && (state_s == ST_ACTIVE);
        fifo.r_ack    = active_tick_s && use_fifo_s && fifo.fifo_avail;
        uf_set_s      = active_tick_s && use_fifo_s && !fifo.fifo_avail;
        if (!use_fifo_s) begin
            pix_sel_s = pat_pix_s;
        end else if (fifo.fifo_avail) begin
            pix_sel_s = fifo.pixel_in;
        end else begin
            pix_sel_s = {DATA_W{1'b0}};
        end
    end

    // Registered video outputs; they decode the state of the same tick, so
    // they trail the FSM by one pix_en tick.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            pixel_out   <= {DATA_W{1'b0}};
            frame_valid <= 1'b0;
            line_valid  <= 1'b0;
            frame_done  <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            // frame_done is one clk wide even though pix_en is a slower strobe.
            frame_done <= pix_en && frame_end_s;
            if (pix_en) begin
                line_valid  <= (state_s == ST_ACTIVE);
                frame_valid <= (state_s != ST_IDLE);
                if (state_s == ST_ACTIVE) begin
                    pixel_out <= pix_sel_s;
                end else begin
                    pixel_out <= pixel_out;
                end
            end else begin
                line_valid <= line_valid;
            end
            // A new underflow in the clear cycle keeps the flag set.
            if (uf_set_s) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end else begin
                underflow <= underflow;
            end
        end
    end

endmodule

// File: tb/tb_video_out_stream.sv
// Directed testbench for video_out_stream with a tiny frame
// (WIDTH=4, HEIGHT=2, H_BLANK=2, V_BLANK=3) and pix_en every 2nd clk.
// A queue models the show-ahead FIFO; expected values are hand-derived.
module tb_video_out_stream;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int HB = 2;
    localparam int VB = 3;

    logic          clk = 1'b0;
    logic          RST;
    logic          pix_en;
    logic          en;
    logic          underflow_clr;
    logic [DW-1:0] pixel_out;
    logic          frame_valid;
    logic          line_valid;
    logic          frame_done;
    logic          underflow;
`ifdef VIDEO_OUT_PATTERN_EN
    logic          pattern_sel;
`endif

    video_out_stream_if #(.DATA_W(DW)) fifo_bus ();

    video_out_stream #(
        .DATA_W(DW), .WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB)
    ) dut (
        .clk          (clk),
        .RST          (RST),
        .pix_en       (pix_en),
        .en           (en),
        .fifo         (fifo_bus),
        .pixel_out    (pixel_out),
        .frame_valid  (frame_valid),
        .line_valid   (line_valid),
        .frame_done   (frame_done),
        .underflow    (underflow),
`ifdef VIDEO_OUT_PATTERN_EN
        .pattern_sel  (pattern_sel),
`endif
        .underflow_clr(underflow_clr)
    );

    always #5 clk = ~clk;

    int            tests_run    = 0;
    int            tests_failed = 0;
    logic [DW-1:0] fifo_q[$];
    logic          lv_log[$];
    logic          fv_log[$];
    logic          uf_log[$];
    logic [DW-1:0] px_log[$];
    int            ack_cnt;
    int            fd_cnt;

    task automatic drive_fifo();
        if (fifo_q.size() != 0) begin
            fifo_bus.fifo_avail = 1'b1;
            fifo_bus.pixel_in   = fifo_q[0];
        end else begin
            fifo_bus.fifo_avail = 1'b0;
            fifo_bus.pixel_in   = '0;
        end
    endtask

    task automatic clear_logs();
        lv_log.delete(); fv_log.delete(); uf_log.delete(); px_log.delete();
        ack_cnt = 0;
        fd_cnt  = 0;
    endtask

    task automatic fill_fifo(input int n);
        for (int i = 1; i <= n; i++) fifo_q.push_back(DW'(i));
    endtask

    // One pix_en tick: a clk with pix_en=1 then a clk with pix_en=0.
    task automatic do_tick();
        logic ack;
        @(negedge clk);
        pix_en = 1'b1;
        drive_fifo();
        #1 ack = fifo_bus.r_ack;
        @(posedge clk);
        if (ack && fifo_q.size() != 0) void'(fifo_q.pop_front());
        #1;
        lv_log.push_back(line_valid);
        fv_log.push_back(frame_valid);
        uf_log.push_back(underflow);
        px_log.push_back(pixel_out);
        if (frame_done) fd_cnt++;
        if (ack) ack_cnt++;
        @(negedge clk);
        pix_en = 1'b0;
        drive_fifo();
        #1 if (fifo_bus.r_ack) ack_cnt++;
        @(posedge clk);
        #1 if (frame_done) fd_cnt++;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        RST = 1'b1; pix_en = 1'b0; en = 1'b0; underflow_clr = 1'b0;
`ifdef VIDEO_OUT_PATTERN_EN
        pattern_sel = 1'b0;
`endif
        fifo_q.delete();
        drive_fifo();
        @(negedge clk);
        RST = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests_run++;
        if ({pixel_out, frame_valid, line_valid, frame_done, underflow, fifo_bus.r_ack} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs got px=%0d fv=%b lv=%b fd=%b uf=%b ack=%b required all 0",
                     pixel_out, frame_valid, line_valid, frame_done, underflow, fifo_bus.r_ack);
        end
    endtask

    task automatic test_frame();
        int exp_px;
        logic exp_lv, exp_fv;
        do_reset();
        en = 1'b1;
        fill_fifo(8);
        run_ticks(20);
        for (int t = 1; t <= 20; t++) begin
            exp_lv = (t >= 5 && t <= 8) || (t >= 11 && t <= 14);
            exp_fv = (t >= 5 && t <= 14);
            exp_px = (t < 5) ? 0 : (t <= 8) ? t - 4 : (t <= 10) ? 4 : (t <= 14) ? t - 6 : 8;
            tests_run++;
            if (lv_log[t-1] !== exp_lv || fv_log[t-1] !== exp_fv || px_log[t-1] !== DW'(exp_px)) begin
                tests_failed++;
                $display("FAIL frame_tick%0d got lv=%b fv=%b px=%0d required lv=%b fv=%b px=%0d",
                         t, lv_log[t-1], fv_log[t-1], px_log[t-1], exp_lv, exp_fv, exp_px);
            end
        end
        tests_run++;
        if (ack_cnt !== 8 || fd_cnt !== 1 || uf_log[19] !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_counts got ack=%0d fd=%0d uf=%b required ack=8 fd=1 uf=0",
                     ack_cnt, fd_cnt, uf_log[19]);
        end
    endtask

    task automatic test_fifo_empty();
        int fv_hi;
        do_reset();
        en = 1'b1;
        run_ticks(10);
        fv_hi = 0;
        foreach (fv_log[i]) if (fv_log[i] || lv_log[i]) fv_hi++;
        tests_run++;
        if (fv_hi !== 0 || ack_cnt !== 0) begin
            tests_failed++;
            $display("FAIL empty_idle got valid_ticks=%0d ack=%0d required 0 0", fv_hi, ack_cnt);
        end
        // blk is saturated, so data arriving now starts the frame at once.
        clear_logs();
        fill_fifo(8);
        run_ticks(3);
        tests_run++;
        if (lv_log[0] !== 1'b0 || lv_log[1] !== 1'b1 || px_log[1] !== DW'(1)) begin
            tests_failed++;
            $display("FAIL late_start got lv0=%b lv1=%b px1=%0d required 0 1 1",
                     lv_log[0], lv_log[1], px_log[1]);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        en = 1'b1;
        fill_fifo(5);
        run_ticks(16);
        tests_run++;
        if (px_log[10] !== DW'(5) || px_log[11] !== '0 || px_log[13] !== '0 ||
            lv_log[11] !== 1'b1 || lv_log[13] !== 1'b1 || lv_log[14] !== 1'b0) begin
            tests_failed++;
            $display("FAIL underflow_pixels got px11=%0d px12=%0d px14=%0d lv12=%b lv14=%b lv15=%b required 5 0 0 1 1 0",
                     px_log[10], px_log[11], px_log[13], lv_log[11], lv_log[13], lv_log[14]);
        end
        tests_run++;
        if (uf_log[10] !== 1'b0 || underflow !== 1'b1 || ack_cnt !== 5 || fd_cnt !== 1) begin
            tests_failed++;
            $display("FAIL underflow_flag got uf11=%b uf=%b ack=%0d fd=%0d required 0 1 5 1",
                     uf_log[10], underflow, ack_cnt, fd_cnt);
        end
        @(negedge clk); underflow_clr = 1'b1;
        @(negedge clk); underflow_clr = 1'b0;
        tests_run++;
        if (underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL underflow_clear got %b required 0", underflow);
        end
        // clr held throughout: set wins on the starved pix_en edges.
        do_reset();
        en = 1'b1;
        underflow_clr = 1'b1;
        fill_fifo(5);
        run_ticks(16);
        underflow_clr = 1'b0;
        tests_run++;
        if (uf_log[10] !== 1'b0 || uf_log[11] !== 1'b1 || uf_log[13] !== 1'b1 || uf_log[14] !== 1'b0) begin
            tests_failed++;
            $display("FAIL underflow_set_wins got uf11=%b uf12=%b uf14=%b uf15=%b required 0 1 1 0",
                     uf_log[10], uf_log[11], uf_log[13], uf_log[14]);
        end
    endtask

    task automatic test_en_drop();
        int lv_hi;
        do_reset();
        en = 1'b1;
        fill_fifo(16);
        run_ticks(6);
        en = 1'b0;
        run_ticks(24);
        lv_hi = 0;
        foreach (lv_log[i]) if (lv_log[i]) lv_hi++;
        tests_run++;
        if (lv_hi !== 8 || ack_cnt !== 8 || fd_cnt !== 1 || fifo_q.size() !== 8 || px_log[29] !== DW'(8)) begin
            tests_failed++;
            $display("FAIL en_drop got lv_ticks=%0d ack=%0d fd=%0d left=%0d px=%0d required 8 8 1 8 8",
                     lv_hi, ack_cnt, fd_cnt, fifo_q.size(), px_log[29]);
        end
    endtask

    task automatic test_reset_mid_line();
        do_reset();
        en = 1'b1;
        fill_fifo(8);
        run_ticks(6);
        tests_run++;
        if (lv_log[5] !== 1'b1 || px_log[5] !== DW'(2)) begin
            tests_failed++;
            $display("FAIL pre_reset got lv=%b px=%0d required 1 2", lv_log[5], px_log[5]);
        end
        @(negedge clk); RST = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({pixel_out, frame_valid, line_valid, frame_done} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset got px=%0d fv=%b lv=%b fd=%b required all 0",
                     pixel_out, frame_valid, line_valid, frame_done);
        end
        @(negedge clk); RST = 1'b0;
        fifo_q.delete();
        fill_fifo(8);
        clear_logs();
        run_ticks(8);
        tests_run++;
        if (lv_log[3] !== 1'b0 || lv_log[4] !== 1'b1 || px_log[4] !== DW'(1) || fv_log[3] !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart got lv4=%b lv5=%b px5=%0d fv4=%b required 0 1 1 0",
                     lv_log[3], lv_log[4], px_log[4], fv_log[3]);
        end
    endtask

`ifdef VIDEO_OUT_PATTERN_EN
    task automatic test_pattern();
        int exp_r0[4] = '{0, 1, 2, 3};
        int exp_r1[4] = '{1, 0, 3, 2};
        do_reset();
        en = 1'b1;
        pattern_sel = 1'b1;
        run_ticks(16);
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if (px_log[4+c] !== DW'(exp_r0[c]) || px_log[10+c] !== DW'(exp_r1[c])) begin
                tests_failed++;
                $display("FAIL pattern_col%0d got r0=%0d r1=%0d required %0d %0d",
                         c, px_log[4+c], px_log[10+c], exp_r0[c], exp_r1[c]);
            end
        end
        tests_run++;
        if (ack_cnt !== 0 || underflow !== 1'b0 || fd_cnt !== 1) begin
            tests_failed++;
            $display("FAIL pattern_flags got ack=%0d uf=%b fd=%0d required 0 0 1", ack_cnt, underflow, fd_cnt);
        end
    endtask
`endif

    initial begin
        RST = 1'b1; pix_en = 1'b0; en = 1'b0; underflow_clr = 1'b0;
`ifdef VIDEO_OUT_PATTERN_EN
        pattern_sel = 1'b0;
`endif
        drive_fifo();
        clear_logs();
        test_reset();
        test_frame();
        test_fifo_empty();
        test_underflow();
        test_en_drop();
        test_reset_mid_line();
`ifdef VIDEO_OUT_PATTERN_EN
        test_pattern();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
